// File: rtl/cfa_pkg.sv
// Shared defaults and counter sizing for the CFA diagonal window block.
package cfa_pkg;
    localparam int DEFAULT_DATA_W = 12;
    localparam int DEFAULT_IMG_W  = 640;
    localparam int DEFAULT_IMG_H  = 480;

    // Width able to hold column and row counts up to max(w, h) - 1.
    function automatic int cnt_width(input int w, input int h);
        return $clog2((w > h) ? w : h);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_IMG_W, DEFAULT_IMG_H);
endpackage

// File: rtl/cfa_diag_window_if.sv
// Pixel input stream and diagonal window output bundle for cfa_diag_window.
interface cfa_diag_window_if
    import cfa_pkg::*;
#(
    parameter int DataBitWidth = DEFAULT_DATA_W
);
    logic                    pix_valid;
    logic                    sof;
    logic [DataBitWidth-1:0] G_in;
    logic [DataBitWidth-1:0] RB_in;
    logic                    out_valid;
    logic                    frame_done;
    logic [DataBitWidth-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
    logic [DataBitWidth-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;

    modport master (
        output pix_valid, sof, G_in, RB_in,
        input  out_valid, frame_done,
        input  G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
        input  RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1
    );

    modport slave (
        input  pix_valid, sof, G_in, RB_in,
        output out_valid, frame_done,
        output G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
        output RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1
    );
endinterface

// File: rtl/cfa_line_delay.sv
// One line of column-addressed storage with registered read; the read address
// is the column of the next expected pixel, so dout is ready when it arrives.
module cfa_line_delay #(
    parameter int Depth     = 640,
    parameter int DataWidth = 24,
    parameter int AddrWidth = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [AddrWidth-1:0] rd_addr,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] dout
);
    logic [DataWidth-1:0] mem [Depth];
    logic [DataWidth-1:0] dout_reg;

    // Storage is deliberately not reset; stale rows are never emitted.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[wr_addr] <= din;
            dout_reg     <= mem[rd_addr];
        end
    end

    assign dout = dout_reg;
endmodule

// File: rtl/cfa_diag_window.sv
// 3x3 diagonal-neighbour window over a G/RB raster stream, one window per pixel.
// Define CFA_WINDOW_OUT_REG_EN to add one extra output register stage (latency 2).
module cfa_diag_window
    import cfa_pkg::*;
#(
    parameter int DataBitWidth = DEFAULT_DATA_W,
    parameter int ImgWidth     = DEFAULT_IMG_W,
    parameter int ImgHeight    = DEFAULT_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    cfa_diag_window_if.slave bus
);
    localparam int CntW  = cnt_width(ImgWidth, ImgHeight);
    localparam int AddrW = $clog2(ImgWidth);
    localparam int PixW  = 2 * DataBitWidth;
    localparam logic [CntW-1:0] XLast = CntW'(ImgWidth - 1);
    localparam logic [CntW-1:0] YLast = CntW'(ImgHeight - 1);
    localparam logic [CntW-1:0] Two   = CntW'(2);

    logic            accept;
    logic            win_ok;
    logic            last_pix;
    logic [CntW-1:0] x_reg, y_reg;
    logic [CntW-1:0] x_cur, y_cur;
    logic [CntW-1:0] x_next, y_next;
    logic [PixW-1:0] cur_pix;
    logic [PixW-1:0] ld_din [2];
    logic [PixW-1:0] ld_q [2];
    logic [PixW-1:0] row_y_sr [2];
    logic [PixW-1:0] row_y2_sr [2];
    logic [PixW-1:0] tap [4];
    logic            valid_reg, done_reg;

    assign accept  = bus.pix_valid & ~rst;
    assign cur_pix = {bus.G_in, bus.RB_in};

    // Position of the pixel on the bus now, and of the one expected after it.
    always_comb begin
        x_cur  = bus.sof ? '0 : x_reg;
        y_cur  = bus.sof ? '0 : y_reg;
        x_next = x_cur + CntW'(1);
        y_next = y_cur;
        if (x_cur == XLast) begin
            x_next = '0;
            y_next = (y_cur == YLast) ? '0 : y_cur + CntW'(1);
        end
    end

    assign win_ok   = accept && (x_cur >= Two) && (y_cur >= Two);
    assign last_pix = (x_cur == XLast) && (y_cur == YLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            valid_reg <= win_ok;
            done_reg  <= win_ok & last_pix;
            if (accept) begin
                x_reg <= x_next;
                y_reg <= y_next;
            end
        end
    end

    // Cascade: line 0 yields row y-1, line 1 yields row y-2 at the current column.
    assign ld_din[0] = cur_pix;
    assign ld_din[1] = ld_q[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ld
        cfa_line_delay #(
            .Depth    (ImgWidth),
            .DataWidth(PixW),
            .AddrWidth(AddrW)
        ) u_line_delay (
            .clk    (clk),
            .en     (accept),
            .wr_addr(x_cur[AddrW-1:0]),
            .rd_addr(x_next[AddrW-1:0]),
            .din    (ld_din[gi]),
            .dout   (ld_q[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            row_y_sr[0]  <= cur_pix;
            row_y_sr[1]  <= row_y_sr[0];
            row_y2_sr[0] <= ld_q[1];
            row_y2_sr[1] <= row_y2_sr[0];
        end
    end

    // Tap order: (y-2,x-2), (y-2,x), (y,x-2), (y,x) == m1_m1, m1_p1, p1_m1, p1_p1.
    assign tap[0] = row_y2_sr[1];
    assign tap[1] = ld_q[1];
    assign tap[2] = row_y_sr[1];
    assign tap[3] = cur_pix;

    for (genvar gi = 0; gi < 4; gi++) begin : g_win
        logic [DataBitWidth-1:0] g_reg, rb_reg;
        logic [DataBitWidth-1:0] g_out, rb_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                g_reg  <= '0;
                rb_reg <= '0;
            end else if (win_ok) begin
                g_reg  <= tap[gi][PixW-1:DataBitWidth];
                rb_reg <= tap[gi][DataBitWidth-1:0];
            end
        end

`ifdef CFA_WINDOW_OUT_REG_EN
        logic [DataBitWidth-1:0] g_out_reg, rb_out_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                g_out_reg  <= '0;
                rb_out_reg <= '0;
            end else begin
                g_out_reg  <= g_reg;
                rb_out_reg <= rb_reg;
            end
        end

        assign g_out  = g_out_reg;
        assign rb_out = rb_out_reg;
`else
        assign g_out  = g_reg;
        assign rb_out = rb_reg;
`endif
    end

`ifdef CFA_WINDOW_OUT_REG_EN
    logic valid_out_reg, done_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_reg <= 1'b0;
            done_out_reg  <= 1'b0;
        end else begin
            valid_out_reg <= valid_reg;
            done_out_reg  <= done_reg;
        end
    end

    assign bus.out_valid  = valid_out_reg;
    assign bus.frame_done = done_out_reg;
`else
    assign bus.out_valid  = valid_reg;
    assign bus.frame_done = done_reg;
`endif

    assign bus.G_m1_m1  = g_win[0].g_out;
    assign bus.G_m1_p1  = g_win[1].g_out;
    assign bus.G_p1_m1  = g_win[2].g_out;
    assign bus.G_p1_p1  = g_win[3].g_out;
    assign bus.RB_m1_m1 = g_win[0].rb_out;
    assign bus.RB_m1_p1 = g_win[1].rb_out;
    assign bus.RB_p1_m1 = g_win[2].rb_out;
    assign bus.RB_p1_p1 = g_win[3].rb_out;
endmodule

// File: tb/tb_cfa_diag_window.sv
// Bench for cfa_diag_window on an 8x6 image: ramp and random frames, gaps,
// mid-frame reset and sof abort, checked against a frame-buffer model.
module tb_cfa_diag_window;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 12;
`ifdef CFA_WINDOW_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [8*DW-1:0] RAMP_43 =
        {12'd18, 12'd20, 12'd50, 12'd52, 12'h812, 12'h814, 12'h832, 12'h834};
    localparam logic [8*DW-1:0] NEW_22 =
        {12'd0, 12'd2, 12'd32, 12'd34, 12'h800, 12'h802, 12'h820, 12'h822};

    typedef struct packed {
        logic [8*DW-1:0] w;
        logic            done;
        logic [31:0]     cyc;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfa_diag_window_if #(.DataBitWidth(DW)) bus ();

    cfa_diag_window #(
        .DataBitWidth(DW),
        .ImgWidth    (W),
        .ImgHeight   (H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;
    int mx = 0, my = 0;
    int gap_err = 0, hold_err = 0, rst_recent = 0;
    logic [DW-1:0] img_g [H][W];
    logic [DW-1:0] img_rb [H][W];
    logic [8*DW-1:0] last_w;
    win_t exp_q[$];
    win_t obs_q[$];
    bit   vin_hist[$];

    // One clock: drive inputs, advance the frame model, sample outputs after the edge.
    task automatic step(input logic v, input logic s, input logic [DW-1:0] g,
                        input logic [DW-1:0] rb, input logic r);
        win_t e, o;
        logic [8*DW-1:0] w_now;
        rst = r; bus.pix_valid = v; bus.sof = s; bus.G_in = g; bus.RB_in = rb;
        if (r) begin
            mx = 0; my = 0; rst_recent = LAT + 1;
        end else if (v) begin
            if (s) begin mx = 0; my = 0; end
            img_g[my][mx] = g; img_rb[my][mx] = rb;
            if (mx >= 2 && my >= 2) begin
                e.w = {img_g[my-2][mx-2], img_g[my-2][mx], img_g[my][mx-2], img_g[my][mx],
                       img_rb[my-2][mx-2], img_rb[my-2][mx], img_rb[my][mx-2], img_rb[my][mx]};
                e.done = (mx == W-1) && (my == H-1);
                e.cyc  = 32'(step_no + LAT - 1);
                exp_q.push_back(e);
            end
            if (mx == W-1) begin mx = 0; my = (my == H-1) ? 0 : my + 1; end
            else mx++;
        end
        vin_hist.push_back(v && !r);
        @(posedge clk); #1;
        w_now = {bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1,
                 bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1};
        if (bus.out_valid === 1'b1) begin
            o.w = w_now; o.done = bus.frame_done; o.cyc = 32'(step_no);
            obs_q.push_back(o);
            if (step_no - LAT + 1 >= 0 && !vin_hist[step_no - LAT + 1]) gap_err++;
        end else begin
            if (bus.frame_done !== 1'b0) gap_err++;
            if (rst_recent == 0 && w_now !== last_w) hold_err++;
        end
        last_w = w_now;
        if (rst_recent > 0) rst_recent--;
        step_no++;
    endtask

    // kind 0: G = x+16y, RB = 0x800+x+16y; kind 1: random samples.
    task automatic drive_frame(input int kind, input int gap_pct, input bit with_sof, input int n_pix);
        int cnt = 0;
        logic [DW-1:0] g, rb;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (cnt < n_pix) begin
                    while ($urandom_range(0, 99) < gap_pct)
                        step(1'b0, 1'b0, DW'($urandom), DW'($urandom), 1'b0);
                    if (kind == 0) begin
                        g = DW'(x + 16*y); rb = DW'(12'h800 + x + 16*y);
                    end else begin
                        g = DW'($urandom); rb = DW'($urandom);
                    end
                    step(1'b1, with_sof && x == 0 && y == 0, g, rb, 1'b0);
                    cnt++;
                end
            end
        end
    endtask

    task automatic drain();
        repeat (LAT + 1) step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset(input bit mid_frame);
        logic [8*DW-1:0] w_now;
        if (mid_frame) drive_frame(1, 0, 1'b1, 20);
        repeat (3) step(1'b1, 1'b1, DW'($urandom), DW'($urandom), 1'b1);
        w_now = {bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1,
                 bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1};
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_now[i*DW +: DW] !== '0) begin
                n_fail++; $display("FAIL reset_window[%0d] got %h want 000", 7 - i, w_now[i*DW +: DW]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ramp_frame();
        int nd = 0;
        exp_q.delete(); obs_q.delete();
        drive_frame(0, 0, 1'b1, W*H);
        drain();
        n_checks++;
        if (obs_q.size() != 24) begin
            n_fail++; $display("FAIL ramp_count got %0d want 24", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ramp_win[%0d] got w=%h done=%b cyc=%0d want w=%h done=%b cyc=%0d",
                         i, obs_q[i].w, obs_q[i].done, obs_q[i].cyc, exp_q[i].w, exp_q[i].done, exp_q[i].cyc);
            end
        end
        if (obs_q.size() > 8) begin
            n_checks++;
            if (obs_q[8].w !== RAMP_43) begin
                n_fail++; $display("FAIL ramp_centre_3_2 got %h want %h", obs_q[8].w, RAMP_43);
            end
        end
        foreach (obs_q[i]) if (obs_q[i].done) nd++;
        n_checks++;
        if (nd != 1 || obs_q.size() == 0 || obs_q[obs_q.size()-1].done !== 1'b1) begin
            n_fail++; $display("FAIL ramp_frame_done got count=%0d want 1 on last window", nd);
        end
    endtask

    task automatic test_random_gaps();
        int nd;
        gap_err = 0; hold_err = 0;
        for (int f = 0; f < 2; f++) begin
            nd = 0;
            exp_q.delete(); obs_q.delete();
            drive_frame(f, 40, 1'b1, W*H);
            drain();
            n_checks++;
            if (obs_q.size() != 24) begin
                n_fail++; $display("FAIL gaps_count[%0d] got %0d want 24", f, obs_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL gaps_win[%0d][%0d] got w=%h done=%b cyc=%0d want w=%h done=%b cyc=%0d",
                             f, i, obs_q[i].w, obs_q[i].done, obs_q[i].cyc, exp_q[i].w, exp_q[i].done, exp_q[i].cyc);
                end
            end
            foreach (obs_q[i]) if (obs_q[i].done) nd++;
            n_checks++;
            if (nd != 1) begin
                n_fail++; $display("FAIL gaps_frame_done[%0d] got %0d want 1", f, nd);
            end
        end
        n_checks++;
        if (gap_err != 0) begin
            n_fail++; $display("FAIL gaps_valid_after_gap got %0d events want 0", gap_err);
        end
        n_checks++;
        if (hold_err != 0) begin
            n_fail++; $display("FAIL gaps_output_hold got %0d changes want 0", hold_err);
        end
    endtask

    // Two frames with no sof, relying on reset-cleared counters and wrap.
    task automatic test_back_to_back();
        int nd = 0;
        exp_q.delete(); obs_q.delete();
        drive_frame(1, 0, 1'b0, W*H);
        drive_frame(1, 0, 1'b0, W*H);
        drain();
        n_checks++;
        if (obs_q.size() != 48) begin
            n_fail++; $display("FAIL b2b_count got %0d want 48", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_win[%0d] got w=%h done=%b cyc=%0d want w=%h done=%b cyc=%0d",
                         i, obs_q[i].w, obs_q[i].done, obs_q[i].cyc, exp_q[i].w, exp_q[i].done, exp_q[i].cyc);
            end
        end
        foreach (obs_q[i]) if (obs_q[i].done) nd++;
        n_checks++;
        if (nd != 2) begin
            n_fail++; $display("FAIL b2b_frame_done got %0d want 2", nd);
        end
    endtask

    // Random frame cut off where pixel (5,2) would be; that pixel starts a ramp frame.
    task automatic test_abort();
        int nd = 0;
        exp_q.delete(); obs_q.delete();
        drive_frame(1, 0, 1'b1, 2*W + 5);
        drive_frame(0, 0, 1'b1, W*H);
        drain();
        n_checks++;
        if (obs_q.size() != 27) begin
            n_fail++; $display("FAIL abort_count got %0d want 27", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_win[%0d] got w=%h done=%b cyc=%0d want w=%h done=%b cyc=%0d",
                         i, obs_q[i].w, obs_q[i].done, obs_q[i].cyc, exp_q[i].w, exp_q[i].done, exp_q[i].cyc);
            end
        end
        if (obs_q.size() > 3) begin
            n_checks++;
            if (obs_q[3].w !== NEW_22) begin
                n_fail++; $display("FAIL abort_first_new got %h want %h", obs_q[3].w, NEW_22);
            end
        end
        foreach (obs_q[i]) if (obs_q[i].done) nd++;
        n_checks++;
        if (nd != 1 || obs_q.size() == 0 || obs_q[obs_q.size()-1].done !== 1'b1) begin
            n_fail++; $display("FAIL abort_frame_done got count=%0d want 1 on last window", nd);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.G_in = '0; bus.RB_in = '0;
        test_reset(1'b0);
        test_ramp_frame();
        test_random_gaps();
        test_reset(1'b1);
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
